oclib_uart_rx_ext: RTL and testbench
====================================

# oclib_uart_rx_ext

Parametrised UART receiver for the oclib serial path, replacing the fixed 8N1 receiver where links need other frame formats. Supports a configurable data width, a runtime baud divisor, 1 or 2 stop bits, optional parity, majority-vote sampling, break detection and an internal FIFO with fill level. It sits between a board RX pin and any oclib valid/ready consumer, such as a command parser or a `oclib_uart_tx` loopback.

## Interface
- `DataWidth`, 8: data bits per frame, 5..9, LSB first on the wire.
- `StopBits`, 1: stop bits checked per frame, 1 or 2.
- `DivisorWidth`, 16: width of `baudDivisor`.
- `FifoDepth`, 4: receive FIFO entries, power of two, 2..64.
- `SyncCycles`, 2: input synchroniser flops on `rx`, at least 2.
- `clock` in, 1: sole clock.
- `reset` in, 1: asynchronous, active-high reset.
- `baudDivisor` in, DivisorWidth: clock cycles per bit. Values below 8 are treated as 8.
- `parityMode` in, 2: 0 = none, 1 = even, 2 = odd, 3 = none.
- `clearError` in, 1: clears the sticky errors.
- `error` out, 4: sticky error flags. [0] framing, [1] parity, [2] overflow, [3] break.
- `rx` in, 1: serial input, idle high.
- `rxData` out, DataWidth: FIFO head.
- `rxValid` out, 1: FIFO not empty.
- `rxReady` in, 1: consumer accepts the head word.
- `fifoLevel` out, $clog2(FifoDepth)+1: current FIFO occupancy.
- `rxActive` out, 1: high in every state except StIdle.

## Operation
- `rx` passes through `SyncCycles` flops, which reset to 1. All sampling uses the synchronised value `rxS`.
- At start detection, `baudDivisor` is latched as D, with a minimum of 8. Changes during a frame take effect on the next frame.
- A bit counter runs from 0 to D-1 within each bit. Three samples are taken at counts H-1, H and H+1, where H = D>>1. The bit value is the majority of the three, registered at count H+1.
- States: StIdle, StStart, StData, StParity, StStop, StBreak.
- **StIdle:** on a 1->0 edge of `rxS`, clear the counter and go to StStart.
- **StStart:** if the start vote is 1, treat it as a glitch and return to StIdle with no error. Otherwise go to StData when the counter reaches D-1.
- **StData:** shift in `DataWidth` votes, LSB first. After the last data bit:
  - go to StParity if parity is active (mode 1 or 2 and the macro is defined);
  - otherwise go to StStop.
- **StParity:** compare the vote with the expected parity bit. Even mode: the XOR of the data bits. Odd mode: its inverse. A mismatch sets error[1].
- **StStop:** take a vote for each stop bit. Any stop vote of 0 sets error[0].
  - After the vote for the last stop bit, push the word and go directly to StIdle. The remainder of the bit time is not waited out.
  - Break exception: if all data votes, the parity vote (if used) and the first stop vote are 0, set error[3] instead of error[0], push nothing, and go to StBreak.
- **StBreak:** wait for `rxS`=1, then go to StIdle.
- Words with parity or framing errors are still pushed. Break frames are never pushed.
- **FIFO:** a circular buffer with read and write pointers one bit wider than the address.
  - A push while full drops the new word and sets error[2]. The FIFO contents are unchanged.
  - A push and a pop in the same cycle while full: the pop frees the slot, so the push succeeds with no overflow.
- **Errors:** each flag is sticky. `clearError` clears all flags, but an error event in the same cycle sets its bit anyway; set wins over clear.
- **Reset:** asynchronous. Every state, counter, pointer and error flag clears immediately, including mid-frame. A partial frame is discarded.

## Timing
- Reset values:
  - `rxData`=0, `rxValid`=0, `fifoLevel`=0, `error`=0, `rxActive`=0.
  - Synchroniser flops = 1.
- Start edge to `rxActive`: SyncCycles+1 clocks after the `rx` fall.
- Push happens at count H+1 of the last stop bit. `rxValid` and the `fifoLevel` increment are visible on the next clock.
- Pop occurs on any cycle with `rxValid && rxReady`. `rxData` shows the next entry on the following clock.
- Back-to-back frames with zero idle gap are received without loss, because the receiver is back in StIdle about half a bit before the next start edge.
- `error` bits update one clock after the triggering vote or push.

## Configuration
- `OCLIB_UART_RX_PARITY_EN` defined:
  - StParity and the parity checker are built;
  - `parityMode` 1 and 2 insert one parity bit after the data bits.
- Not defined:
  - `parityMode` is ignored and the frame has no parity bit;
  - StParity is unreachable and removed;
  - error[1] is tied to 0.

## Test plan
- D=16, mode 0, 8N1, send 0xA5 then 0x3C with no gap -> two pops, 0xA5 then 0x3C, `error`=0.
- Macro defined, D=16, mode 1, send 0x07 with a parity bit of 0 -> 0x07 is pushed and error[1]=1. Pulse `clearError` -> `error`=0.
- `rx` low for 4 clocks only, D=16 -> glitch rejected: no push, `error`=0, `rxActive` returns to 0.
- Hold `rx` low for 12 bit times, then release -> error[3]=1, no push, and the receiver is in StIdle after `rx` rises. Next frame 0x55 is received correctly.
- FifoDepth=4 with `rxReady`=0, send 5 frames -> `fifoLevel`=4, error[2]=1, and pops return only the first four words.
- Assert `reset` mid-StData, then release and send 0x81 -> no stale word; 0x81 is received alone.

Source files
------------

// File: rtl/oclib_uart_rx_ext.sv
// oclib_uart_rx_ext: configurable UART receiver with majority-vote sampling, break detection and RX FIFO.
// Define OCLIB_UART_RX_PARITY_EN to build the optional parity bit support.
module oclib_uart_rx_ext #(
  parameter int DataWidth    = 8,
  parameter int StopBits     = 1,
  parameter int DivisorWidth = 16,
  parameter int FifoDepth    = 4,
  parameter int SyncCycles   = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [DivisorWidth-1:0]      baudDivisor,
  input  logic [1:0]                   parityMode,
  input  logic                         clearError,
  output logic [3:0]                   error,
  input  logic                         rx,
  output logic [DataWidth-1:0]         rxData,
  output logic                         rxValid,
  input  logic                         rxReady,
  output logic [$clog2(FifoDepth):0]   fifoLevel,
  output logic                         rxActive
);
  localparam int AW = $clog2(FifoDepth);
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BREAK  = 3'd5;
  localparam logic [DivisorWidth-1:0] MIN_DIV = DivisorWidth'(8);
  localparam logic [AW:0] FULL_LVL = FifoDepth[AW:0];
`ifdef OCLIB_UART_RX_PARITY_EN
  localparam bit PAR_BUILD = 1'b1;
`else
  localparam bit PAR_BUILD = 1'b0;
`endif

  function automatic logic exp_parity(input logic [DataWidth-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  logic [SyncCycles-1:0]   sync_r;
  logic                    rx_s;
  logic                    rx_prev_r;
  logic [2:0]              state_r;
  logic [DivisorWidth-1:0] cnt_r;
  logic [DivisorWidth-1:0] div_r;
  logic [DivisorWidth-1:0] half_s;
  logic [1:0]              samp_r;
  logic [3:0]              bit_idx_r;
  logic                    stop_idx_r;
  logic [DataWidth-1:0]    shift_r;
  logic                    par_on_r;
  logic                    par_odd_r;
  logic                    par_vote_r;
  logic                    vote_s;
  logic                    at_vote_s;
  logic                    bit_end_s;
  logic                    last_stop_s;
  logic                    brk_s;
  logic                    push_s;
  logic                    fr_err_s;
  logic                    par_err_s;
  logic [DataWidth-1:0]    mem_r [FifoDepth];
  logic [AW:0]             wr_ptr_r;
  logic [AW:0]             rd_ptr_r;
  logic [AW:0]             level_s;
  logic                    pop_s;
  logic                    full_s;
  logic                    wr_ok_s;
  logic                    ovf_s;
  logic [3:0]              err_r;

  assign rx_s        = sync_r[SyncCycles-1];
  assign half_s      = div_r >> 1;
  assign vote_s      = (samp_r[0] & samp_r[1]) | (samp_r[0] & rx_s) | (samp_r[1] & rx_s);
  assign at_vote_s   = (cnt_r == half_s + DivisorWidth'(1));
  assign bit_end_s   = (cnt_r == div_r - DivisorWidth'(1));
  assign last_stop_s = (stop_idx_r == 1'(StopBits - 1));

  // A break is an all-zero frame through the first stop vote; it replaces the framing error.
  assign brk_s    = (state_r == ST_STOP) && at_vote_s && !stop_idx_r && !vote_s &&
                    (shift_r == '0) && !(par_on_r && par_vote_r);
  assign push_s   = (state_r == ST_STOP) && at_vote_s && last_stop_s && !brk_s;
  assign fr_err_s = (state_r == ST_STOP) && at_vote_s && !vote_s && !brk_s;
`ifdef OCLIB_UART_RX_PARITY_EN
  assign par_err_s = (state_r == ST_PARITY) && at_vote_s &&
                     (vote_s != exp_parity(shift_r, par_odd_r));
`else
  assign par_err_s = 1'b0;
`endif

  assign level_s = wr_ptr_r - rd_ptr_r;
  assign full_s  = (level_s == FULL_LVL);
  assign pop_s   = rxValid && rxReady;
  assign wr_ok_s = push_s && (!full_s || pop_s);
  assign ovf_s   = push_s && full_s && !pop_s;

  assign rxData    = mem_r[rd_ptr_r[AW-1:0]];
  assign rxValid   = (level_s != '0);
  assign fifoLevel = level_s;
  assign error     = err_r;
  assign rxActive  = (state_r != ST_IDLE);

  // Input synchroniser, idles high.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_r    <= '1;
      rx_prev_r <= 1'b1;
    end else begin
      sync_r    <= {sync_r[SyncCycles-2:0], rx};
      rx_prev_r <= rx_s;
    end
  end

  // Frame sequencer: bit timing, majority sampling and shift register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      div_r      <= MIN_DIV;
      samp_r     <= 2'b11;
      bit_idx_r  <= 4'd0;
      stop_idx_r <= 1'b0;
      shift_r    <= '0;
      par_on_r   <= 1'b0;
      par_odd_r  <= 1'b0;
      par_vote_r <= 1'b0;
    end else begin
      if (cnt_r == half_s - DivisorWidth'(1)) samp_r[0] <= rx_s;
      if (cnt_r == half_s) samp_r[1] <= rx_s;
      if (state_r == ST_IDLE || state_r == ST_BREAK || bit_end_s) cnt_r <= '0;
      else cnt_r <= cnt_r + DivisorWidth'(1);
      case (state_r)
        ST_IDLE: begin
          if (rx_prev_r && !rx_s) begin
            state_r   <= ST_START;
            div_r     <= (baudDivisor < MIN_DIV) ? MIN_DIV : baudDivisor;
            par_on_r  <= PAR_BUILD && (parityMode == 2'd1 || parityMode == 2'd2);
            par_odd_r <= parityMode[1];
          end
        end
        ST_START: begin
          if (at_vote_s && vote_s) begin
            state_r <= ST_IDLE;
          end else if (bit_end_s) begin
            state_r   <= ST_DATA;
            bit_idx_r <= 4'd0;
          end
        end
        ST_DATA: begin
          if (at_vote_s) shift_r <= {vote_s, shift_r[DataWidth-1:1]};
          if (bit_end_s) begin
            if (bit_idx_r == 4'(DataWidth - 1)) begin
              state_r    <= par_on_r ? ST_PARITY : ST_STOP;
              stop_idx_r <= 1'b0;
            end else begin
              bit_idx_r <= bit_idx_r + 4'd1;
            end
          end
        end
`ifdef OCLIB_UART_RX_PARITY_EN
        ST_PARITY: begin
          if (at_vote_s) par_vote_r <= vote_s;
          if (bit_end_s) begin
            state_r    <= ST_STOP;
            stop_idx_r <= 1'b0;
          end
        end
`endif
        ST_STOP: begin
          if (at_vote_s) begin
            if (brk_s) state_r <= ST_BREAK;
            else if (last_stop_s) state_r <= ST_IDLE;
          end else if (bit_end_s) begin
            stop_idx_r <= 1'b1;
          end
        end
        ST_BREAK: begin
          if (rx_s) state_r <= ST_IDLE;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Receive FIFO; a pop in the same cycle frees the slot for a push while full.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      for (int i = 0; i < FifoDepth; i++) mem_r[i] <= '0;
    end else begin
      if (wr_ok_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= shift_r;
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + 1'b1;
    end
  end

  // Sticky error flags; a new event wins over clearError.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_r <= 4'b0000;
    end else begin
      err_r <= (clearError ? 4'b0000 : err_r) | {brk_s, ovf_s, par_err_s, fr_err_s};
    end
  end
endmodule

// File: tb/tb_oclib_uart_rx_ext.sv
// Scoreboard bench for oclib_uart_rx_ext: a serial driver with a frame-level reference model
// queues expected words; a monitor pops and compares on every accepted FIFO head.
module tb_oclib_uart_rx_ext;
  localparam int DW = 8;
  localparam int FD = 4;
  localparam int SC = 2;
`ifdef OCLIB_UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [15:0]   baudDivisor = 16'd16;
  logic [1:0]    parityMode = 2'd0;
  logic          clearError = 1'b0;
  logic [3:0]    error;
  logic          rx = 1'b1;
  logic [DW-1:0] rxData;
  logic          rxValid;
  logic          rxReady;
  logic [2:0]    fifoLevel;
  logic          rxActive;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [3:0]    exp_err = 4'b0000;
  int            bit_clks = 16;
  bit            rand_ready = 1'b0;
  bit            ready_level = 1'b1;

  oclib_uart_rx_ext #(.DataWidth(DW), .StopBits(1), .DivisorWidth(16), .FifoDepth(FD),
                      .SyncCycles(SC)) dut (
    .clock(clock), .reset(reset), .baudDivisor(baudDivisor), .parityMode(parityMode),
    .clearError(clearError), .error(error), .rx(rx), .rxData(rxData), .rxValid(rxValid),
    .rxReady(rxReady), .fifoLevel(fifoLevel), .rxActive(rxActive)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Consumer handshake: changes just after the rising edge so it is stable at the monitor's sample.
  initial begin
    rxReady = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (rand_ready) rxReady = 1'($urandom_range(0, 1));
      else rxReady = ready_level;
    end
  end

  // Monitor: every accepted head word must match the oldest expected word.
  always @(negedge clock) begin
    if (!reset && rxValid && rxReady) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got 0x%0h, expected no word", rxData);
      end else begin
        check("rxData", 32'(rxData), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic send_bit(input logic b);
    rx = b;
    repeat (bit_clks) @(negedge clock);
  endtask

  // Reference model of one frame, then the frame itself on the wire.
  task automatic send_frame(input logic [DW-1:0] data, input logic [1:0] mode,
                            input bit par_flip, input bit stop_val, input int gap);
    bit par_used;
    bit pbit;
    par_used   = PAR_EN && (mode == 2'd1 || mode == 2'd2);
    pbit       = (^data) ^ (mode == 2'd2) ^ par_flip;
    parityMode = mode;
    if (data == '0 && !(par_used && pbit) && !stop_val) begin
      exp_err[3] = 1'b1;
    end else begin
      if (!stop_val) exp_err[0] = 1'b1;
      if (par_used && par_flip) exp_err[1] = 1'b1;
      if (exp_q.size() < FD) exp_q.push_back(data);
      else exp_err[2] = 1'b1;
    end
    send_bit(1'b0);
    for (int i = 0; i < DW; i++) send_bit(data[i]);
    if (par_used) send_bit(pbit);
    send_bit(stop_val);
    for (int i = 0; i < gap; i++) send_bit(1'b1);
    check("error", 32'(error), 32'(exp_err));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clock);
      n++;
    end
    repeat (2) @(negedge clock);
    check("drain", 32'(exp_q.size()), 32'd0);
    check("fifoLevel_empty", 32'(fifoLevel), 32'd0);
  endtask

  task automatic clear_err();
    clearError = 1'b1;
    @(negedge clock);
    clearError = 1'b0;
    exp_err = 4'b0000;
    @(negedge clock);
    check("error_cleared", 32'(error), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check("reset_rxData", 32'(rxData), 32'd0);
    check("reset_rxValid", 32'(rxValid), 32'd0);
    check("reset_fifoLevel", 32'(fifoLevel), 32'd0);
    check("reset_error", 32'(error), 32'd0);
    check("reset_rxActive", 32'(rxActive), 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clock);

    // Back-to-back frames, no idle gap between them
    send_frame(8'hA5, 2'd0, 1'b0, 1'b1, 0);
    send_frame(8'h3C, 2'd0, 1'b0, 1'b1, 2);
    wait_drain();

    // Even parity with a wrong parity bit (0x07 needs 1)
    send_frame(8'h07, 2'd1, 1'b1, 1'b1, 1);
    wait_drain();
    clear_err();

    // Short glitch, with the start-detect latency check
    rx = 1'b0;
    repeat (2) @(negedge clock);
    check("active_latency_early", 32'(rxActive), 32'd0);
    @(negedge clock);
    check("active_latency", 32'(rxActive), 32'd1);
    @(negedge clock);
    rx = 1'b1;
    repeat (40) @(negedge clock);
    check("glitch_rxActive", 32'(rxActive), 32'd0);
    check("glitch_level", 32'(fifoLevel), 32'd0);
    check("glitch_error", 32'(error), 32'd0);

    // Line break: 12 bit times low
    rx = 1'b0;
    repeat (12 * 16) @(negedge clock);
    exp_err[3] = 1'b1;
    check("break_active", 32'(rxActive), 32'd1);
    rx = 1'b1;
    repeat (6) @(negedge clock);
    check("break_idle", 32'(rxActive), 32'd0);
    check("break_error", 32'(error), 32'(exp_err));
    check("break_level", 32'(fifoLevel), 32'd0);
    clear_err();
    send_frame(8'h55, 2'd0, 1'b0, 1'b1, 1);
    wait_drain();

    // Overflow: five frames into a four-entry FIFO with no consumer
    ready_level = 1'b0;
    repeat (2) @(negedge clock);
    for (int i = 0; i < 5; i++) send_frame(8'(8'h11 * (i + 1)), 2'd0, 1'b0, 1'b1, 1);
    check("ovf_level", 32'(fifoLevel), 32'd4);
    check("ovf_head", 32'(rxData), 32'(exp_q[0]));
    ready_level = 1'b1;
    wait_drain();
    clear_err();

    // Divisor below the minimum behaves as 8
    baudDivisor = 16'd3;
    bit_clks = 8;
    send_frame(8'hC3, 2'd0, 1'b0, 1'b1, 0);
    send_frame(8'h18, 2'd0, 1'b0, 1'b1, 1);
    wait_drain();
    baudDivisor = 16'd16;
    bit_clks = 16;

    // Reset mid-data discards the FIFO and the partial frame
    ready_level = 1'b0;
    repeat (2) @(negedge clock);
    send_frame(8'h3A, 2'd0, 1'b0, 1'b1, 1);
    send_bit(1'b0);
    repeat (3) send_bit(1'b1);
    reset = 1'b1;
    rx = 1'b1;
    exp_q.delete();
    exp_err = 4'b0000;
    repeat (2) @(negedge clock);
    check("rst_level", 32'(fifoLevel), 32'd0);
    check("rst_valid", 32'(rxValid), 32'd0);
    check("rst_active", 32'(rxActive), 32'd0);
    check("rst_data", 32'(rxData), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    reset = 1'b0;
    ready_level = 1'b1;
    repeat (20) @(negedge clock);
    send_frame(8'h81, 2'd0, 1'b0, 1'b1, 1);
    wait_drain();

    // Randomised frames: divisor, parity mode, data, corrupted parity/stop bits, gaps
    rand_ready = 1'b1;
    for (int f = 0; f < 30; f++) begin
      logic [DW-1:0] d;
      logic [1:0]    m;
      bit            pf;
      bit            sv;
      int            g;
      d  = 8'($urandom);
      m  = 2'($urandom_range(0, 3));
      pf = ($urandom_range(0, 7) == 0);
      sv = ($urandom_range(0, 7) != 0);
      g  = $urandom_range(0, 2);
      if (!sv && g == 0) g = 1;
      bit_clks = $urandom_range(8, 24);
      baudDivisor = 16'(bit_clks);
      send_frame(d, m, pf, sv, g);
      if (f % 10 == 9) begin
        wait_drain();
        clear_err();
      end
    end
    rand_ready = 1'b0;
    ready_level = 1'b1;
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
